hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and selects EX-stage operand forwarding. It also runs a request/ready handshake with a variable-latency data memory. While a MEM-stage access waits, it freezes the upper pipeline and injects bubbles into the MEM/WB register so no writeback is duplicated.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fwd_unit.sv | 26 ++
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline control logic.
//   FWD_*  : EX-stage operand source select encodings
//   mem_state_e : data-memory handshake FSM states
package riscv_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_ERR  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX-stage operand.
//   rs_e                 : source register of the EX instruction
//   rd_m / reg_write_m   : destination and write enable of the MEM instruction
//   rd_w / reg_write_w   : destination and write enable of the WB instruction
//   fwd_sel              : FWD_MEM, FWD_WB or FWD_RF (MEM has priority)
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and data-memory sequencing controller for the 5-stage core.
//   Inputs : ID/EX/MEM/WB register indices and control bits, dmem_ready
//   Outputs: stall/flush controls for PC and pipeline registers, EX operand
//            forwarding selects, dmem_req, sticky mem_err, saturating
//            stall_cnt (cycles with StallF asserted)
//
//   state  | meaning
//   M_IDLE | no access pending; a MEM access without ready starts a wait
//   M_WAIT | access outstanding, pipeline frozen until ready or timeout
//   M_ERR  | one cycle: access aborted, MEM/WB bubbled, mem_err set
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemAccM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // Counter value at which the next increment reaches MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       mem_stall;
  logic       load_use;
  logic [1:0] fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_b)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    unique case (state_q)
      M_IDLE: begin
        if (MemAccM && !dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = M_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      M_WAIT: begin
        if (dmem_ready) begin
          state_d    = M_IDLE;
          wait_cnt_d = 8'd0;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = M_ERR;
          end
        end
      end
      M_ERR: begin
        state_d    = M_IDLE;
        wait_cnt_d = 8'd0;
      end
      default: begin
        state_d    = M_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // A memory stall overrides load-use and branch handling; those act once the
  // stall releases because the EX contents are held meanwhile.
  always_comb begin
    dmem_req  = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      dmem_req  = MemAccM && (state_q != M_ERR);
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        FlushW = (state_q == M_ERR);
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_err_d   = mem_err_q | (state_q == M_ERR);
    stall_cnt_d = stall_cnt_q;
    if (StallF && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= M_IDLE;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a vector table plus hand-built
// multi-cycle sequences, checked through a scoreboard queue.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        MemReadE, PCSrcE, RegWriteM, MemAccM, RegWriteW, dmem_ready;
  logic        dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemAccM(MemAccM),
    .RdW(RdW), .RegWriteW(RegWriteW), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // ctl = {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  // err = -1 means mem_err is not compared for that cycle.
  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic       mre, pcs;
    logic [4:0] rdm;
    logic       rwm, mam;
    logic [4:0] rdw;
    logic       rww, rdy, rstv;
    logic [7:0] ctl;
    logic [1:0] fa, fb;
    int         err;
    int         cnt;
  } vec_t;

  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b0110_0010;
  localparam logic [7:0] C_BR    = 8'b0000_0110;
  localparam logic [7:0] C_REQ   = 8'b1000_0000;
  localparam logic [7:0] C_MSTL  = 8'b1111_1001;
  localparam logic [7:0] C_REQBR = 8'b1000_0110;
  localparam logic [7:0] C_ERR   = 8'b0000_0001;

  vec_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t v(input string name,
                             input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                             input logic mre, pcs,
                             input logic [4:0] rdm, input logic rwm, mam,
                             input logic [4:0] rdw, input logic rww, rdy, rstv,
                             input logic [7:0] ctl, input logic [1:0] fa, fb,
                             input int err, cnt);
    vec_t t;
    t.name = name; t.rs1d = rs1d; t.rs2d = rs2d; t.rs1e = rs1e; t.rs2e = rs2e;
    t.rde = rde; t.mre = mre; t.pcs = pcs; t.rdm = rdm; t.rwm = rwm; t.mam = mam;
    t.rdw = rdw; t.rww = rww; t.rdy = rdy; t.rstv = rstv; t.ctl = ctl;
    t.fa = fa; t.fb = fb; t.err = err; t.cnt = cnt;
    return t;
  endfunction

  // Memory access, no other hazards.
  function automatic vec_t mv(input string name, input logic pcs, rdy, rstv,
                              input logic [7:0] ctl, input int err, cnt);
    return v(name, 0,0,0,0,0, 0,pcs, 0,0,1, 0,0, rdy,rstv, ctl, 2'b00,2'b00, err,cnt);
  endfunction

  function automatic vec_t idle(input string name, input int err, cnt);
    return v(name, 0,0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, C_NONE, 2'b00,2'b00, err,cnt);
  endfunction

  task automatic chk(input string name, input string fld, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", name, fld, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    @(posedge clk);
    #1;
    rst = t.rstv; Rs1D = t.rs1d; Rs2D = t.rs2d; Rs1E = t.rs1e; Rs2E = t.rs2e;
    RdE = t.rde; MemReadE = t.mre; PCSrcE = t.pcs; RdM = t.rdm;
    RegWriteM = t.rwm; MemAccM = t.mam; RdW = t.rdw; RegWriteW = t.rww;
    dmem_ready = t.rdy;
    sb_q.push_back(t);
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "ctl", 32'({dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}),
          32'(e.ctl));
      chk(e.name, "ForwardAE", 32'(ForwardAE), 32'(e.fa));
      chk(e.name, "ForwardBE", 32'(ForwardBE), 32'(e.fb));
      chk(e.name, "stall_cnt", stall_cnt, 32'(e.cnt));
      if (e.err >= 0) chk(e.name, "mem_err", 32'(mem_err), 32'(e.err));
    end
  end

  initial begin
    rst = 1'b1;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemReadE = 0; PCSrcE = 0; RegWriteM = 0; MemAccM = 0; RegWriteW = 0;
    dmem_ready = 0;
    repeat (2) @(posedge clk);

    //          name           rs1d rs2d rs1e rs2e rde mre pcs rdm rwm mam rdw rww rdy rst ctl  fa  fb  err cnt
    tbl.push_back(v("rst_hold",   5,0,7,0,5,  1,1, 7,1,1, 0,0, 0,1, C_NONE, 2'b00,2'b00, 0,0));
    tbl.push_back(idle("idle", 0, 0));
    tbl.push_back(v("lu_x5",      5,0,0,0,5,  1,0, 0,0,0, 0,0, 0,0, C_LU,   2'b00,2'b00, 0,0));
    tbl.push_back(v("lu_fwd_wb",  0,0,5,0,0,  0,0, 0,0,0, 5,1, 0,0, C_NONE, 2'b01,2'b00, 0,1));
    tbl.push_back(v("lu_x0",      0,0,0,0,0,  1,0, 0,0,0, 0,0, 0,0, C_NONE, 2'b00,2'b00, 0,1));
    tbl.push_back(v("fwd_mem_pri",0,0,7,7,0,  0,0, 7,1,0, 7,1, 0,0, C_NONE, 2'b10,2'b10, 0,1));
    tbl.push_back(v("fwd_mix",    0,0,7,3,0,  0,0, 7,1,0, 3,1, 0,0, C_NONE, 2'b10,2'b01, 0,1));
    tbl.push_back(v("fwd_x0",     0,0,0,0,0,  0,0, 0,1,0, 0,1, 0,0, C_NONE, 2'b00,2'b00, 0,1));
    tbl.push_back(v("fwd_nowr",   0,0,4,4,0,  0,0, 4,0,0, 4,0, 0,0, C_NONE, 2'b00,2'b00, 0,1));
    tbl.push_back(v("lu_rs2",     1,9,0,0,9,  1,0, 0,0,0, 0,0, 0,0, C_LU,   2'b00,2'b00, 0,1));
    tbl.push_back(v("br_lu",      9,0,0,0,9,  1,1, 0,0,0, 0,0, 0,0, C_BR,   2'b00,2'b00, 0,2));
    tbl.push_back(v("br",         0,0,0,0,0,  0,1, 0,0,0, 0,0, 0,0, C_BR,   2'b00,2'b00, 0,2));
    tbl.push_back(v("lu_nomatch", 8,10,0,0,9, 1,0, 0,0,0, 0,0, 0,0, C_NONE, 2'b00,2'b00, 0,2));
    tbl.push_back(mv("zero_wait", 0,1,0, C_REQ,   0,2));
    tbl.push_back(mv("st_wait1",  0,0,0, C_MSTL,  0,2));
    tbl.push_back(mv("st_wait2",  0,0,0, C_MSTL,  0,3));
    tbl.push_back(mv("st_wait3",  0,0,0, C_MSTL,  0,4));
    tbl.push_back(mv("st_done",   0,1,0, C_REQ,   0,5));
    tbl.push_back(idle("st_after", 0, 5));
    tbl.push_back(mv("br_wait1",  1,0,0, C_MSTL,  0,5));
    tbl.push_back(mv("br_wait2",  1,0,0, C_MSTL,  0,6));
    tbl.push_back(mv("br_rel",    1,1,0, C_REQBR, 0,7));
    tbl.push_back(idle("br_after", 0, 7));

    foreach (tbl[i]) step(tbl[i]);

    // Timeout: MEM_TIMEOUT stalled cycles, one M_ERR cycle, then sticky error.
    for (int i = 0; i < MEM_TIMEOUT; i++) step(mv("to_wait", 0,0,0, C_MSTL, 0, 7 + i));
    step(mv("to_err", 0,0,0, C_ERR, -1, 7 + MEM_TIMEOUT));
    step(idle("to_sticky1", 1, 7 + MEM_TIMEOUT));
    step(idle("to_sticky2", 1, 7 + MEM_TIMEOUT));

    // Reset in the middle of a wait abandons the access without an error.
    step(mv("rw_a",   0,0,0, C_MSTL, 1, 23));
    step(mv("rw_b",   0,0,0, C_MSTL, 1, 24));
    step(mv("rw_rst", 0,0,1, C_NONE, 1, 25));
    step(idle("rw_after", 0, 0));
    // A fresh access gets the full timeout, showing the wait counter restarted.
    for (int i = 0; i < MEM_TIMEOUT; i++) step(mv("rw_wait", 0,0,0, C_MSTL, 0, i));
    step(mv("rw_err", 0,0,0, C_ERR, -1, MEM_TIMEOUT));
    step(idle("rw_sticky", 1, MEM_TIMEOUT));

    @(negedge clk);
    #1;
    chk("scoreboard", "pending", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
